// File: rtl/systolic_array_4x4.sv
// systolic_array_4x4: output-stationary 4x4 int8 systolic array.
// A enters from the left edge, B from the top edge, both skewed by row/column
// index so that A[m][k] and B[k][n] meet in PE(m,n) on the same cycle
// (cnt = k+m+n). Each PE keeps its own 32-bit accumulator, which is C[m][n].
//
// Build option: define SA_INPUT_OFFSET_EN to add a 9-bit signed input_offset
// port that is added to every real A operand (padding zeros are not offset).
module systolic_array_4x4 #(
    parameter int DATA_BITS  = 32,
    parameter int DATAC_BITS = 128,
    parameter int K_LEN      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sa_rst_n,
    input  logic [DATA_BITS-1:0]  local_buffer_A0,
    input  logic [DATA_BITS-1:0]  local_buffer_A1,
    input  logic [DATA_BITS-1:0]  local_buffer_A2,
    input  logic [DATA_BITS-1:0]  local_buffer_A3,
    input  logic [DATA_BITS-1:0]  local_buffer_B0,
    input  logic [DATA_BITS-1:0]  local_buffer_B1,
    input  logic [DATA_BITS-1:0]  local_buffer_B2,
    input  logic [DATA_BITS-1:0]  local_buffer_B3,
`ifdef SA_INPUT_OFFSET_EN
    input  logic signed [8:0]     input_offset,
`endif
    output logic [DATAC_BITS-1:0] local_buffer_C0,
    output logic [DATAC_BITS-1:0] local_buffer_C1,
    output logic [DATAC_BITS-1:0] local_buffer_C2,
    output logic [DATAC_BITS-1:0] local_buffer_C3,
    output logic                  done
);

`ifdef SA_INPUT_OFFSET_EN
    localparam int A_BITS = 10;
`else
    localparam int A_BITS = 8;
`endif

    // PE(3,3) sees its last operand pair at cnt = (K_LEN-1)+3+3
    localparam logic [4:0] LAST_MAC = 5'(K_LEN + 5);

    logic [4:0]               cnt_q;
    logic                     done_q;

    logic [DATA_BITS-1:0]     a_word [4];
    logic [DATA_BITS-1:0]     b_word [4];
    logic signed [A_BITS-1:0] a_val  [4][4];  // [k][m], operand-ready A
    logic signed [7:0]        b_val  [4][4];  // [k][n]

    logic signed [A_BITS-1:0] feed_a [4];
    logic signed [7:0]        feed_b [4];

    logic signed [A_BITS-1:0] a_q    [4][4];
    logic signed [7:0]        b_q    [4][4];
    logic signed [31:0]       acc_q  [4][4];

    logic signed [A_BITS-1:0] a_in   [4][4];
    logic signed [7:0]        b_in   [4][4];
    logic signed [31:0]       prod   [4][4];

    logic [DATAC_BITS-1:0]    c_row  [4];

    // Unpack the buffer words into per-element operands
    always_comb begin
        a_word[0] = local_buffer_A0;
        a_word[1] = local_buffer_A1;
        a_word[2] = local_buffer_A2;
        a_word[3] = local_buffer_A3;
        b_word[0] = local_buffer_B0;
        b_word[1] = local_buffer_B1;
        b_word[2] = local_buffer_B2;
        b_word[3] = local_buffer_B3;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
`ifdef SA_INPUT_OFFSET_EN
                a_val[k][i] = A_BITS'(signed'(a_word[k][8*i +: 8])) + A_BITS'(input_offset);
`else
                a_val[k][i] = signed'(a_word[k][8*i +: 8]);
`endif
                b_val[k][i] = signed'(b_word[k][8*i +: 8]);
            end
        end
    end

    // Skewed edge feeders: row/column i gets element k = cnt-i while in range
    always_comb begin
        int         k;
        logic [1:0] ki;
        k  = 0;
        ki = '0;
        for (int i = 0; i < 4; i++) begin
            feed_a[i] = '0;
            feed_b[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            k  = int'(cnt_q) - i;
            ki = k[1:0];
            if (k >= 0 && k < K_LEN) begin
                feed_a[i] = a_val[ki][i];
                feed_b[i] = b_val[ki][i];
            end
        end
    end

    // PE operand routing and products
    always_comb begin
        for (int m = 0; m < 4; m++) begin
            a_in[m][0] = feed_a[m];
            for (int n = 1; n < 4; n++) begin
                a_in[m][n] = a_q[m][n-1];
            end
        end
        for (int n = 0; n < 4; n++) begin
            b_in[0][n] = feed_b[n];
            for (int m = 1; m < 4; m++) begin
                b_in[m][n] = b_q[m-1][n];
            end
        end
        for (int m = 0; m < 4; m++) begin
            for (int n = 0; n < 4; n++) begin
                prod[m][n] = 32'(a_in[m][n]) * 32'(b_in[m][n]);
            end
        end
    end

    // Array state: async reset, sync clear on sa_rst_n low, MAC while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            for (int m = 0; m < 4; m++) begin
                for (int n = 0; n < 4; n++) begin
                    a_q[m][n]   <= '0;
                    b_q[m][n]   <= '0;
                    acc_q[m][n] <= '0;
                end
            end
        end else if (!sa_rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            for (int m = 0; m < 4; m++) begin
                for (int n = 0; n < 4; n++) begin
                    a_q[m][n]   <= '0;
                    b_q[m][n]   <= '0;
                    acc_q[m][n] <= '0;
                end
            end
        end else if (!done_q) begin
            cnt_q  <= cnt_q + 5'd1;
            done_q <= (cnt_q == LAST_MAC);
            for (int m = 0; m < 4; m++) begin
                for (int n = 0; n < 4; n++) begin
                    a_q[m][n]   <= a_in[m][n];
                    b_q[m][n]   <= b_in[m][n];
                    acc_q[m][n] <= acc_q[m][n] + prod[m][n];
                end
            end
        end
    end

    // Pack accumulators into C rows; C[m][n] at bits [32n+31:32n]
    always_comb begin
        for (int m = 0; m < 4; m++) begin
            c_row[m] = '0;
            for (int n = 0; n < 4; n++) begin
                c_row[m][32*n +: 32] = acc_q[m][n];
            end
        end
    end

    assign local_buffer_C0 = c_row[0];
    assign local_buffer_C1 = c_row[1];
    assign local_buffer_C2 = c_row[2];
    assign local_buffer_C3 = c_row[3];
    assign done            = done_q;

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Directed bench for systolic_array_4x4: reset, identity tile and done latency,
// int8 extremes, mid-run clear, async reset, clear/done collision, K_LEN=2 build.
module tb_systolic_array_4x4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sa_rst_n;
    logic         sa_rst_n2;
    logic [31:0]  a0, a1, a2, a3, b0, b1, b2, b3;
    logic [31:0]  ones;
    logic [127:0] c0, c1, c2, c3;
    logic [127:0] d0, d1, d2, d3;
    logic         done, done2;
`ifdef SA_INPUT_OFFSET_EN
    logic signed [8:0] input_offset;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_array_4x4 dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sa_rst_n        (sa_rst_n),
        .local_buffer_A0 (a0),
        .local_buffer_A1 (a1),
        .local_buffer_A2 (a2),
        .local_buffer_A3 (a3),
        .local_buffer_B0 (b0),
        .local_buffer_B1 (b1),
        .local_buffer_B2 (b2),
        .local_buffer_B3 (b3),
`ifdef SA_INPUT_OFFSET_EN
        .input_offset    (input_offset),
`endif
        .local_buffer_C0 (c0),
        .local_buffer_C1 (c1),
        .local_buffer_C2 (c2),
        .local_buffer_C3 (c3),
        .done            (done)
    );

    systolic_array_4x4 #(.K_LEN(2)) dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .sa_rst_n        (sa_rst_n2),
        .local_buffer_A0 (ones),
        .local_buffer_A1 (ones),
        .local_buffer_A2 (ones),
        .local_buffer_A3 (ones),
        .local_buffer_B0 (ones),
        .local_buffer_B1 (ones),
        .local_buffer_B2 (ones),
        .local_buffer_B3 (ones),
`ifdef SA_INPUT_OFFSET_EN
        .input_offset    (input_offset),
`endif
        .local_buffer_C0 (d0),
        .local_buffer_C1 (d1),
        .local_buffer_C2 (d2),
        .local_buffer_C3 (d3),
        .done            (done2)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_c(input string tag, input logic [127:0] e0, input logic [127:0] e1,
                         input logic [127:0] e2, input logic [127:0] e3);
        chk({tag, ".C0"}, c0, e0);
        chk({tag, ".C1"}, c1, e1);
        chk({tag, ".C2"}, c2, e2);
        chk({tag, ".C3"}, c3, e3);
    endtask

    task automatic set_ab(input logic [31:0] a, input logic [31:0] b);
        a0 = a; a1 = a; a2 = a; a3 = a;
        b0 = b; b1 = b; b2 = b; b3 = b;
    endtask

    task automatic set_identity();
        a0 = 32'h0000_0001; a1 = 32'h0000_0100; a2 = 32'h0001_0000; a3 = 32'h0100_0000;
        b0 = 32'h0302_0100; b1 = 32'h0706_0504; b2 = 32'h0B0A_0908; b3 = 32'h0F0E_0D0C;
    endtask

    // Leaves sa_rst_n low for one posedge, returns at a negedge
    task automatic clear_sa();
        @(negedge clk);
        sa_rst_n = 1'b0;
        @(negedge clk);
    endtask

    localparam logic [127:0] ID_R0 = 128'h00000003_00000002_00000001_00000000;
    localparam logic [127:0] ID_R1 = 128'h00000007_00000006_00000005_00000004;
    localparam logic [127:0] ID_R2 = 128'h0000000B_0000000A_00000009_00000008;
    localparam logic [127:0] ID_R3 = 128'h0000000F_0000000E_0000000D_0000000C;
    localparam logic [127:0] NEG_SQ = {4{32'h0001_0000}};   // 4 * (-128*-128)
    localparam logic [127:0] POS_NEG = {4{32'hFFFF_0200}};  // 4 * (127*-128) = -65024
    localparam logic [127:0] TWOS = {4{32'd2}};

    initial begin
        rst_n     = 1'b0;
        sa_rst_n  = 1'b0;
        sa_rst_n2 = 1'b0;
        ones      = 32'h0101_0101;
`ifdef SA_INPUT_OFFSET_EN
        input_offset = 9'sd0;
`endif
        set_identity();

        // Reset state
        #12;
        chk_c("reset", '0, '0, '0, '0);
        chk("reset.done", 128'(done), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity tile: done exactly 10 cycles after sa_rst_n rises
        sa_rst_n = 1'b1;
        repeat (9) @(negedge clk);
        chk("ident.done_at9", 128'(done), 128'(1'b0));
        @(negedge clk);
        chk("ident.done_at10", 128'(done), 128'(1'b1));
        chk_c("ident", ID_R0, ID_R1, ID_R2, ID_R3);

        // Inputs changing after done are ignored
        set_ab(32'h8080_8080, 32'h8080_8080);
        repeat (3) @(negedge clk);
        chk("hold.done", 128'(done), 128'(1'b1));
        chk_c("hold", ID_R0, ID_R1, ID_R2, ID_R3);

        // Sync clear drops done and C on the sampling edge
        clear_sa();
        chk("clear.done", 128'(done), 128'(1'b0));
        chk("clear.C2", c2, '0);

        // Extremes: -128 * -128
        sa_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("neg.done", 128'(done), 128'(1'b1));
        chk_c("neg", NEG_SQ, NEG_SQ, NEG_SQ, NEG_SQ);

        // 127 * -128
        set_ab(32'h7F7F_7F7F, 32'h8080_8080);
        clear_sa();
        sa_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk_c("posneg", POS_NEG, POS_NEG, POS_NEG, POS_NEG);

        // Clear mid-run at cnt=5, then fresh identity tile with no residue
        set_ab(32'h8080_8080, 32'h8080_8080);
        clear_sa();
        sa_rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("drop.partial_nonzero", 128'(c0 != '0), 128'(1'b1));
        sa_rst_n = 1'b0;
        set_identity();
        @(negedge clk);
        chk("drop.cleared", c0, '0);
        sa_rst_n = 1'b1;
        repeat (9) @(negedge clk);
        chk("drop.done_at9", 128'(done), 128'(1'b0));
        @(negedge clk);
        chk("drop.done_at10", 128'(done), 128'(1'b1));
        chk_c("drop", ID_R0, ID_R1, ID_R2, ID_R3);

        // Async reset between edges, mid-run
        set_ab(32'h8080_8080, 32'h8080_8080);
        clear_sa();
        sa_rst_n = 1'b1;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.C0", c0, '0);
        chk("arst.done", 128'(done), 128'(1'b0));
        sa_rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst.idle_C0", c0, '0);
        chk("arst.idle_done", 128'(done), 128'(1'b0));

        // Async reset after done with a non-zero C
        sa_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst2.done_before", 128'(done), 128'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_c("arst2", '0, '0, '0, '0);
        chk("arst2.done", 128'(done), 128'(1'b0));
        sa_rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Clear in the same cycle done would rise: clear wins
        clear_sa();
        sa_rst_n = 1'b1;
        repeat (9) @(negedge clk);
        sa_rst_n = 1'b0;
        @(negedge clk);
        chk("collide.done", 128'(done), 128'(1'b0));
        chk("collide.C3", c3, '0);

        // K_LEN=2 instance, all ones: C=2 everywhere, done after 8 cycles
        sa_rst_n2 = 1'b1;
        repeat (7) @(negedge clk);
        chk("k2.done_at7", 128'(done2), 128'(1'b0));
        @(negedge clk);
        chk("k2.done_at8", 128'(done2), 128'(1'b1));
        chk("k2.C0", d0, TWOS);
        chk("k2.C1", d1, TWOS);
        chk("k2.C2", d2, TWOS);
        chk("k2.C3", d3, TWOS);

`ifdef SA_INPUT_OFFSET_EN
        // Offset 128 cancels A=-128 -> 0; offset 1 -> 4 * (-127) = -508
        set_ab(32'h8080_8080, 32'h0101_0101);
        input_offset = 9'sd128;
        clear_sa();
        sa_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk_c("off128", '0, '0, '0, '0);
        input_offset = 9'sd1;
        clear_sa();
        sa_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk_c("off1", {4{32'hFFFF_FE04}}, {4{32'hFFFF_FE04}}, {4{32'hFFFF_FE04}},
              {4{32'hFFFF_FE04}});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
